frv_pipeline_skid: RTL and testbench

FRV_PIPELINE_SKID -- requirements
Module: frv_pipeline_skid

---
 rtl/frv_pipeline_skid_pkg.sv | 12 +
 rtl/frv_pipeline_skid.sv | 88 ++++++++
 tb/tb_frv_pipeline_skid.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/frv_pipeline_skid_pkg.sv
// Shared core constants for pipeline stages: handshake-buffer state encoding.
package frv_pipeline_skid_pkg;

  localparam int SKID_STATE_W = 2;

  typedef enum logic [SKID_STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/frv_pipeline_skid.sv
// Two-entry skid-buffered pipeline stage register; o_ready depends on state only.
module frv_pipeline_skid
  import frv_pipeline_skid_pkg::*;
#(
  parameter int RLEN = 8
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [RLEN-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            flush,
  output logic [RLEN-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready
);

  skid_state_e     r_state;
  skid_state_e     w_state_nxt;
  logic [RLEN-1:0] r_main;
  logic [RLEN-1:0] r_skid;
  logic [RLEN-1:0] w_main_nxt;
  logic [RLEN-1:0] w_skid_nxt;
  logic            w_in_xfer;
  logic            w_out_xfer;

  assign o_valid    = (r_state != ST_EMPTY);
  assign o_ready    = (r_state != ST_FULL);
  assign o_data     = r_main;
  assign w_in_xfer  = i_valid & o_ready;
  assign w_out_xfer = o_valid & i_ready;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Flush wins over any transfer; the upstream word seen with flush is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_BUSY;
            w_main_nxt  = i_data;
          end
        end
        ST_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = i_data;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = i_data;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt = ST_BUSY;
            w_main_nxt  = r_skid;
          end
        end
        // Illegal encoding 3 falls back to a clean empty buffer.
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frv_pipeline_skid.sv
// Bench for frv_pipeline_skid: directed vector table, corner sequences, random vs queue model.
module tb_frv_pipeline_skid;

  localparam int RLEN = 8;

  logic            g_clk;
  logic            g_resetn;
  logic [RLEN-1:0] i_data;
  logic            i_valid;
  logic            o_ready;
  logic            flush;
  logic [RLEN-1:0] o_data;
  logic            o_valid;
  logic            i_ready;

  int n_tests = 0;
  int n_fail  = 0;

  frv_pipeline_skid #(.RLEN(RLEN)) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .flush   (flush),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic            fl;
    logic            v;
    logic [RLEN-1:0] d;
    logic            rdy;
    logic            ev;
    logic            er;
    logic [RLEN-1:0] ed;
  } vec_t;

  vec_t tbl[16];

  // Reference model: plain FIFO of accepted words, capacity two.
  logic [RLEN-1:0] mq[$];
  logic [RLEN-1:0] m_last;

  function automatic vec_t mk(input logic fl, input logic v, input logic [RLEN-1:0] d,
                              input logic rdy, input logic ev, input logic er,
                              input logic [RLEN-1:0] ed);
    vec_t t;
    t.fl = fl; t.v = v; t.d = d; t.rdy = rdy; t.ev = ev; t.er = er; t.ed = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic fl, input logic v, input logic [RLEN-1:0] d, input logic rdy);
    flush   = fl;
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    flush    = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    g_resetn = 1'b1;
    mq.delete();
    m_last = '0;
  endtask

  initial begin
    logic            r_fl, r_v, r_rdy, pre_ready, pre_valid;
    logic [RLEN-1:0] r_d, exp_d;

    tbl[0]  = mk(0, 1, 8'h11, 1, 1, 1, 8'h11);
    tbl[1]  = mk(0, 1, 8'h22, 1, 1, 1, 8'h22);
    tbl[2]  = mk(0, 1, 8'h33, 1, 1, 1, 8'h33);
    tbl[3]  = mk(0, 0, 8'h00, 1, 0, 1, 8'h33);
    tbl[4]  = mk(0, 1, 8'hA1, 0, 1, 1, 8'hA1);
    tbl[5]  = mk(0, 1, 8'hA2, 0, 1, 0, 8'hA1);
    tbl[6]  = mk(0, 1, 8'h77, 0, 1, 0, 8'hA1);
    tbl[7]  = mk(0, 0, 8'h00, 1, 1, 1, 8'hA2);
    tbl[8]  = mk(0, 0, 8'h00, 1, 0, 1, 8'hA2);
    tbl[9]  = mk(0, 1, 8'hB1, 0, 1, 1, 8'hB1);
    tbl[10] = mk(0, 1, 8'hB2, 0, 1, 0, 8'hB1);
    tbl[11] = mk(1, 1, 8'h55, 0, 0, 1, 8'h00);
    tbl[12] = mk(0, 0, 8'h00, 1, 0, 1, 8'h00);
    tbl[13] = mk(0, 1, 8'hC1, 1, 1, 1, 8'hC1);
    tbl[14] = mk(1, 1, 8'hC2, 1, 0, 1, 8'h00);
    tbl[15] = mk(0, 1, 8'hD4, 1, 1, 1, 8'hD4);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, o_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, o_ready}, {31'd0, tbl[i].er});
      chk($sformatf("vec%0d_data", i), {24'd0, o_data}, {24'd0, tbl[i].ed});
    end

    // Async reset between edges while BUSY, then first transfer right after release.
    do_reset();
    step(0, 1, 8'h5A, 0);
    chk("busy_valid", {31'd0, o_valid}, 32'd1);
    @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    chk("async_valid", {31'd0, o_valid}, 32'd0);
    chk("async_ready", {31'd0, o_ready}, 32'd1);
    chk("async_data", {24'd0, o_data}, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    step(0, 1, 8'h3C, 1);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
    chk("post_rst_data", {24'd0, o_data}, 32'h3C);

    // o_ready must not follow i_ready within a cycle, FULL and BUSY.
    do_reset();
    step(0, 1, 8'hE1, 0);
    step(0, 1, 8'hE2, 0);
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("comb_full_hi", {31'd0, o_ready}, 32'd0);
    i_ready = 1'b0;
    #1;
    chk("comb_full_lo", {31'd0, o_ready}, 32'd0);
    step(0, 0, 8'h00, 1);
    chk("comb_busy_data", {24'd0, o_data}, 32'hE2);
    i_ready = 1'b0;
    #1;
    chk("comb_busy_lo", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    #1;
    chk("comb_busy_hi", {31'd0, o_ready}, 32'd1);

    // Random valid/ready against the FIFO model.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      r_fl  = ($urandom_range(63) == 0);
      r_v   = $urandom_range(1);
      r_rdy = $urandom_range(1);
      r_d   = RLEN'($urandom);
      pre_ready = (mq.size() < 2);
      pre_valid = (mq.size() > 0);
      step(r_fl, r_v, r_d, r_rdy);
      if (r_fl) begin
        mq.delete();
        m_last = '0;
      end else begin
        if (pre_valid && r_rdy) m_last = mq.pop_front();
        if (r_v && pre_ready) mq.push_back(r_d);
      end
      exp_d = (mq.size() > 0) ? mq[0] : m_last;
      chk("rnd_valid", {31'd0, o_valid}, {31'd0, (mq.size() > 0)});
      chk("rnd_ready", {31'd0, o_ready}, {31'd0, (mq.size() < 2)});
      chk("rnd_data", {24'd0, o_data}, {24'd0, exp_d});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
